// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the core load/store path
//   (port C) and a debug/loader DMA port (port D). The core has fixed
//   priority. A saturating starvation counter forces a DMA grant after
//   STARVE_LIMIT consecutive denied cycles. A LOCK state lets DMA hold the
//   memory across a multi-beat burst.
//
// Ports
//   clk, rst                  : clock and synchronous active-high reset
//   core_req/we/addr/wdata/strb : core request channel
//   core_gnt, core_stall      : core accepted / core must hold this cycle
//   core_rvalid, core_rdata   : core read return (one cycle after grant)
//   dma_req/lock/we/addr/wdata/strb : DMA request channel (lock = burst continues)
//   dma_gnt                   : DMA accepted this cycle
//   dma_rvalid, dma_rdata     : DMA read return (one cycle after grant)
//   mem_we/addr/wdata/strb    : to data_memory, driven from the granted port
//   mem_rdata                 : from data_memory (combinational read)
//   busy                      : LOCK state or any grant this cycle
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    input  logic [DW/8-1:0] core_strb,
    output logic            core_gnt,
    output logic            core_stall,
    output logic            core_rvalid,
    output logic [DW-1:0]   core_rdata,
    input  logic            dma_req,
    input  logic            dma_lock,
    input  logic            dma_we,
    input  logic [AW-1:0]   dma_addr,
    input  logic [DW-1:0]   dma_wdata,
    input  logic [DW/8-1:0] dma_strb,
    output logic            dma_gnt,
    output logic            dma_rvalid,
    output logic [DW-1:0]   dma_rdata,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_strb,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t     state, state_nxt;
    logic [7:0] starve_cnt;
    logic       core_gnt_c, dma_gnt_c;
    logic       core_vld_p1, dma_vld_p1;

    // Grant decision; all grants are suppressed while reset is held.
    always_comb begin
        core_gnt_c = 1'b0;
        dma_gnt_c  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (dma_req && starve_cnt >= LIMIT) dma_gnt_c  = 1'b1;
                    else if (core_req)                  core_gnt_c = 1'b1;
                    else if (dma_req)                   dma_gnt_c  = 1'b1;
                end
                LOCK: dma_gnt_c = dma_req;
                default: ;
            endcase
        end
    end

    // Memory mux; with no grant the core address/data pass through harmlessly.
    always_comb begin
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
        mem_we    = core_gnt_c && core_we;
        mem_strb  = core_gnt_c ? core_strb : '0;
        if (dma_gnt_c) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_we    = dma_we;
            mem_strb  = dma_strb;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (dma_gnt_c && dma_lock) state_nxt = LOCK;
            // Leave on the last beat or when DMA abandons the burst.
            LOCK: if (!dma_req || (dma_gnt_c && !dma_lock)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p1: registered read return, one cycle after a granted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= 8'd0;
            core_vld_p1 <= 1'b0;
            dma_vld_p1  <= 1'b0;
            core_rdata  <= '0;
            dma_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (dma_gnt_c || !dma_req)  starve_cnt <= 8'd0;
            else if (starve_cnt != 8'hFF) starve_cnt <= starve_cnt + 8'd1;
            core_vld_p1 <= core_gnt_c && !core_we;
            dma_vld_p1  <= dma_gnt_c && !dma_we;
            if (core_gnt_c && !core_we) core_rdata <= mem_rdata;
            if (dma_gnt_c && !dma_we)   dma_rdata  <= mem_rdata;
        end
    end

    assign core_gnt    = core_gnt_c;
    assign dma_gnt     = dma_gnt_c;
    assign core_stall  = core_req && !core_gnt_c;
    // Gating with rst hides a read return that was launched just before reset.
    assign core_rvalid = core_vld_p1 && !rst;
    assign dma_rvalid  = dma_vld_p1 && !rst;
    assign busy        = !rst && ((state == LOCK) || core_gnt_c || dma_gnt_c);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter with a behavioural data_memory
//   (byte-strobed write on the clock edge, combinational read).
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [3:0]    core_strb;
    logic          core_gnt, core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          dma_req, dma_lock, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [3:0]    dma_strb;
    logic          dma_gnt, dma_rvalid;
    logic [DW-1:0] dma_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_strb;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_strb(core_strb),
        .core_gnt(core_gnt), .core_stall(core_stall),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_strb(dma_strb),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_strb(mem_strb), .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = ram[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_strb[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        core_req = 0; core_we = 0; core_addr = 32'h10; core_wdata = 0; core_strb = 4'hF;
        dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_strb = 4'hF;
    endtask

    task automatic core_read(input logic [31:0] a);
        core_req = 1; core_we = 0; core_addr = a;
    endtask

    task automatic dma_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic lk);
        dma_req = 1; dma_we = 1; dma_addr = a; dma_wdata = d; dma_strb = s; dma_lock = lk;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[8'h04] = 32'hDEADBEEF;   // 0x10
        ram[8'h0C] = 32'h12345678;   // 0x30

        // Reset with both ports requesting
        idle();
        rst = 1;
        core_read(32'h10);
        dma_write(32'h100, 32'h9, 4'hF, 1'b1);
        sample();
        chk("rst_core_gnt", 32'(core_gnt), 0);
        chk("rst_dma_gnt",  32'(dma_gnt), 0);
        chk("rst_mem_we",   32'(mem_we), 0);
        chk("rst_busy",     32'(busy), 0);
        next_cycle();
        sample();
        chk("rst_core_rvalid", 32'(core_rvalid), 0);
        chk("rst_dma_rvalid",  32'(dma_rvalid), 0);
        chk("rst_core_rdata",  core_rdata, 0);
        chk("rst_dma_rdata",   dma_rdata, 0);

        // Core-only read of 0x10
        next_cycle();
        rst = 0;
        idle();
        core_read(32'h10);
        sample();
        chk("cr_gnt",   32'(core_gnt), 1);
        chk("cr_stall", 32'(core_stall), 0);
        chk("cr_busy",  32'(busy), 1);
        chk("cr_addr",  mem_addr, 32'h10);
        next_cycle();
        idle();
        sample();
        chk("cr_rvalid", 32'(core_rvalid), 1);
        chk("cr_rdata",  core_rdata, 32'hDEADBEEF);
        chk("cr_dvalid", 32'(dma_rvalid), 0);
        chk("cr_idle_busy", 32'(busy), 0);
        chk("cr_idle_strb", 32'(mem_strb), 0);
        next_cycle();
        sample();
        chk("cr_rvalid_pulse", 32'(core_rvalid), 0);
        chk("cr_rdata_hold",   core_rdata, 32'hDEADBEEF);

        // Contention: DMA is forced in on cycle 8, core regains cycle 9
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            core_read(32'h10);
            dma_req = 1; dma_we = 0; dma_lock = 0; dma_addr = 32'h30;
            sample();
            chk($sformatf("ct_core_gnt%0d", i), 32'(core_gnt), (i == 8) ? 0 : 1);
            chk($sformatf("ct_dma_gnt%0d", i),  32'(dma_gnt),  (i == 8) ? 1 : 0);
            chk($sformatf("ct_stall%0d", i),    32'(core_stall), (i == 8) ? 1 : 0);
            if (i == 9) begin
                chk("ct_dma_rvalid",  32'(dma_rvalid), 1);
                chk("ct_dma_rdata",   dma_rdata, 32'h12345678);
                chk("ct_core_rvalid", 32'(core_rvalid), 0);
            end
        end
        next_cycle();
        idle();

        // Burst: DMA wins by starvation, then holds LOCK for 4 beats total
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            core_read(32'h10);
            if (i < 12)
                dma_write((i < 8) ? 32'h100 : 32'h100 + 32'(4 * (i - 8)),
                          (i < 8) ? 32'h1 : 32'(i - 7), 4'hF, (i < 11));
            else
                dma_req = 0;
            sample();
            chk($sformatf("bu_stall%0d", i),   32'(core_stall), (i >= 8 && i <= 11) ? 1 : 0);
            chk($sformatf("bu_dma_gnt%0d", i), 32'(dma_gnt),    (i >= 8 && i <= 11) ? 1 : 0);
            if (i == 9) chk("bu_busy_lock", 32'(busy), 1);
        end
        next_cycle();
        idle();
        chk("bu_mem0", ram[8'h40], 32'h1);
        chk("bu_mem1", ram[8'h41], 32'h2);
        chk("bu_mem2", ram[8'h42], 32'h3);
        chk("bu_mem3", ram[8'h43], 32'h4);

        // Lock abort after two beats
        next_cycle();
        dma_write(32'h140, 32'h55, 4'hF, 1'b1);
        sample();
        chk("ab_gnt0", 32'(dma_gnt), 1);
        next_cycle();
        core_read(32'h10);
        dma_write(32'h144, 32'h66, 4'hF, 1'b1);
        sample();
        chk("ab_gnt1",   32'(dma_gnt), 1);
        chk("ab_stall1", 32'(core_stall), 1);
        next_cycle();
        dma_req = 0;
        sample();
        chk("ab_drop_core_gnt", 32'(core_gnt), 0);
        chk("ab_drop_busy",     32'(busy), 1);
        next_cycle();
        sample();
        chk("ab_after_core_gnt", 32'(core_gnt), 1);
        next_cycle();
        idle();
        chk("ab_mem0", ram[8'h50], 32'h55);
        chk("ab_mem1", ram[8'h51], 32'h66);

        // Strobed DMA write then core read of the same word
        next_cycle();
        dma_write(32'h20, 32'hAABBCCDD, 4'b0011, 1'b0);
        sample();
        chk("st_we",   32'(mem_we), 1);
        chk("st_strb", 32'(mem_strb), 32'h3);
        next_cycle();
        idle();
        core_read(32'h20);
        sample();
        chk("st_core_gnt", 32'(core_gnt), 1);
        next_cycle();
        idle();
        sample();
        chk("st_rvalid", 32'(core_rvalid), 1);
        chk("st_rdata",  core_rdata, 32'h0000CCDD);

        // Reset in the middle of a locked burst, right after a granted read
        next_cycle();
        dma_write(32'h148, 32'h77, 4'hF, 1'b1);
        next_cycle();
        dma_req = 1; dma_we = 0; dma_lock = 1; dma_addr = 32'h100;
        sample();
        chk("rl_read_gnt", 32'(dma_gnt), 1);
        next_cycle();
        rst = 1;
        core_read(32'h10);
        sample();
        chk("rl_core_gnt", 32'(core_gnt), 0);
        chk("rl_dma_gnt",  32'(dma_gnt), 0);
        chk("rl_busy",     32'(busy), 0);
        chk("rl_rvalid",   32'(dma_rvalid), 0);
        chk("rl_mem_we",   32'(mem_we), 0);
        next_cycle();
        rst = 0;
        dma_req = 0; dma_lock = 0;
        core_read(32'h10);
        sample();
        chk("rl_after_core_gnt", 32'(core_gnt), 1);
        chk("rl_after_dvalid",   32'(dma_rvalid), 0);
        chk("rl_after_drdata",   dma_rdata, 0);
        next_cycle();
        idle();
        sample();
        chk("rl_after_rvalid", 32'(core_rvalid), 1);
        chk("rl_after_rdata",  core_rdata, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
